// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared data-memory arbiter types and constants.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RWAIT  = 2'd2,
    DONE   = 2'd3
  } dmem_state_t;

  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-port (core / debug) arbiter onto one single-port SRAM.
//   Define DMEM_ARB_RR_EN for round-robin contention, else core always wins.
// Revision : 1.0
// ============================================================================
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] RDM
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  dmem_state_t       state_q;
  grant_t            gnt_q;
  logic              we_q;
  logic [1:0]        cnt_q;
  logic              cen_q, wen_q, oen_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
  logic              c_ready_q, d_ready_q;
`ifdef DMEM_ARB_RR_EN
  grant_t            prio_q;
`endif

  grant_t            gnt_d;
  logic              req_we_d;
  logic [ADDR_W-1:0] req_addr_d;
  logic [DATA_W-1:0] req_wdata_d;

  // On a tie the port named by prio wins; a lone requester always wins.
  function automatic grant_t arbitrate(input logic creq, input logic dreq,
                                       input grant_t prio);
    if (creq && dreq) return prio;
    if (dreq)         return DBG;
    return CORE;
  endfunction

`ifdef DMEM_ARB_RR_EN
  assign gnt_d = arbitrate(c_req, d_req, prio_q);
`else
  assign gnt_d = arbitrate(c_req, d_req, CORE);
`endif

  assign req_we_d    = (gnt_d == DBG) ? d_we    : c_we;
  assign req_addr_d  = (gnt_d == DBG) ? d_addr  : c_addr;
  assign req_wdata_d = (gnt_d == DBG) ? d_wdata : c_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= CORE;
      we_q      <= 1'b0;
      cnt_q     <= 2'd0;
      cen_q     <= 1'b1;
      wen_q     <= 1'b1;
      oen_q     <= 1'b1;
      a_q       <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      c_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      prio_q    <= CORE;
`endif
    end else begin
      c_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (c_req || d_req) begin
            state_q <= ACCESS;
            gnt_q   <= gnt_d;
            we_q    <= req_we_d;
            a_q     <= req_addr_d;
            wdata_q <= req_wdata_d;
            cen_q   <= 1'b0;
            wen_q   <= ~req_we_d;
            oen_q   <= req_we_d;
`ifdef DMEM_ARB_RR_EN
            prio_q  <= (gnt_d == CORE) ? DBG : CORE;
`endif
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q <= DONE;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            oen_q   <= 1'b1;
            if (gnt_q == DBG) d_ready_q <= 1'b1;
            else              c_ready_q <= 1'b1;
          end else begin
            // Strobe stays low for RD_LAT cycles in total, ACCESS included.
            state_q <= RWAIT;
            cnt_q   <= 2'd0;
            wen_q   <= 1'b1;
            cen_q   <= (LAT_LAST == 2'd0);
            oen_q   <= (LAT_LAST == 2'd0);
          end
        end
        RWAIT: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= DONE;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            oen_q   <= 1'b1;
            if (gnt_q == DBG) begin
              d_rdata_q <= RDM;
              d_ready_q <= 1'b1;
            end else begin
              c_rdata_q <= RDM;
              c_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
            cen_q <= (cnt_q + 2'd1 >= LAT_LAST);
            oen_q <= (cnt_q + 2'd1 >= LAT_LAST);
          end
        end
        DONE: begin
          state_q <= IDLE;
          cen_q   <= 1'b1;
          wen_q   <= 1'b1;
          oen_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CEN      = cen_q;
  assign WEN      = wen_q;
  assign OEN      = oen_q;
  assign A        = a_q;
  assign Data2Mem = wdata_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign c_ready  = c_ready_q;
  assign d_ready  = d_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed self-checking bench for dmem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [6:0]  c_addr, d_addr, A;
  logic [31:0] c_wdata, d_wdata, c_rdata, d_rdata, Data2Mem, RDM;
  logic        c_ready, d_ready, CEN, WEN, OEN;

  logic        e_c_req, e_c_we, e_d_req, e_d_we;
  logic [6:0]  e_c_addr, e_d_addr, e_A;
  logic [31:0] e_c_wdata, e_d_wdata, e_c_rdata, e_d_rdata, e_Data2Mem, e_RDM;
  logic        e_c_ready, e_d_ready, e_CEN, e_WEN, e_OEN;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ready(c_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem), .RDM(RDM)
  );

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .c_req(e_c_req), .c_we(e_c_we), .c_addr(e_c_addr), .c_wdata(e_c_wdata),
    .c_rdata(e_c_rdata), .c_ready(e_c_ready),
    .d_req(e_d_req), .d_we(e_d_we), .d_addr(e_d_addr), .d_wdata(e_d_wdata),
    .d_rdata(e_d_rdata), .d_ready(e_d_ready),
    .CEN(e_CEN), .WEN(e_WEN), .OEN(e_OEN), .A(e_A), .Data2Mem(e_Data2Mem),
    .RDM(e_RDM)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int          k;
    logic [2:0]  exp_g;
    logic [2:0]  got_g;
    int          d_seen;
    logic [4:0]  exp_oen3;

    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; RDM = 0;
    e_c_req = 0; e_c_we = 0; e_c_addr = 0; e_c_wdata = 0;
    e_d_req = 0; e_d_we = 0; e_d_addr = 0; e_d_wdata = 0; e_RDM = 0;
    tick(); tick();

    check_val("rst_enables", {29'd0, CEN, WEN, OEN}, 32'h7);
    check_val("rst_A", {25'd0, A}, 32'd0);
    check_val("rst_d2m", Data2Mem, 32'd0);
    check_val("rst_rdata", c_rdata | d_rdata, 32'd0);
    check_val("rst_ready", {30'd0, c_ready, d_ready}, 32'd0);
    rst = 1'b0;
    tick();

    // Contention: both ports hold requests for three transactions.
`ifdef DMEM_ARB_RR_EN
    exp_g = 3'b010;
`else
    exp_g = 3'b000;
`endif
    got_g  = 3'b000;
    d_seen = 0;
    c_req = 1; c_we = 1; c_addr = 7'd1; c_wdata = 32'h11;
    d_req = 1; d_we = 1; d_addr = 7'd2; d_wdata = 32'h22;
    for (int r = 0; r < 3; r++) begin
      k = 0;
      while (!(c_ready || d_ready) && k < 12) begin
        tick();
        k++;
      end
      check_val("tie_done", {31'd0, (k < 12)}, 32'd1);
      got_g[r] = d_ready;
      if (d_ready) d_seen++;
      if (r == 2) begin c_req = 0; d_req = 0; end
      tick();
    end
    check_val("tie_gnt_seq", {29'd0, got_g}, {29'd0, exp_g});
`ifdef DMEM_ARB_RR_EN
    check_val("tie_d_seen", d_seen, 32'd1);
`else
    check_val("tie_d_seen", d_seen, 32'd0);
`endif
    tick();

    // Core write addr 10 data 19.
    c_req = 1; c_we = 1; c_addr = 7'd10; c_wdata = 32'd19;
    tick();
    check_val("wr_c1_strobes", {29'd0, CEN, WEN, OEN}, 32'h1);
    check_val("wr_c1_A", {25'd0, A}, 32'd10);
    check_val("wr_c1_d2m", Data2Mem, 32'd19);
    check_val("wr_c1_ready", {31'd0, c_ready}, 32'd0);
    tick();
    check_val("wr_c2_ready", {30'd0, c_ready, d_ready}, 32'h2);
    check_val("wr_c2_strobes", {29'd0, CEN, WEN, OEN}, 32'h7);
    c_req = 0;
    tick();
    check_val("wr_idle_ready", {31'd0, c_ready}, 32'd0);

    // Core read addr 10, RDM=19, RD_LAT=1.
    c_req = 1; c_we = 0; c_addr = 7'd10; RDM = 32'd19;
    tick();
    check_val("rd_c1_strobes", {29'd0, CEN, WEN, OEN}, 32'h2);
    check_val("rd_c1_A", {25'd0, A}, 32'd10);
    tick();
    check_val("rd_c2_ready", {31'd0, c_ready}, 32'd0);
    tick();
    check_val("rd_c3_ready", {31'd0, c_ready}, 32'd1);
    check_val("rd_c3_crdata", c_rdata, 32'd19);
    check_val("rd_c3_drdata", d_rdata, 32'd0);
    c_req = 0;
    tick();

    // Reset during RWAIT of a debug read.
    d_req = 1; d_we = 0; d_addr = 7'd3; RDM = 32'h77;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_val("rstmid_strobes", {29'd0, CEN, WEN, OEN}, 32'h7);
    check_val("rstmid_ready", {30'd0, c_ready, d_ready}, 32'd0);
    check_val("rstmid_rdata", c_rdata | d_rdata, 32'd0);
    rst = 1'b0; d_req = 0;
    tick();
    check_val("rstmid_noready", {30'd0, c_ready, d_ready}, 32'd0);
    check_val("rstmid_nostrobe", {31'd0, CEN}, 32'd1);

    // Debug write to 5, address changed to 9 mid-flight, then a write to 9.
    d_req = 1; d_we = 1; d_addr = 7'd5; d_wdata = 32'h55;
    tick();
    check_val("lat_c1_A", {25'd0, A}, 32'd5);
    d_addr = 7'd9; d_wdata = 32'h99;
    tick();
    check_val("lat_c2_ready", {31'd0, d_ready}, 32'd1);
    check_val("lat_c2_A", {25'd0, A}, 32'd5);
    check_val("lat_c2_d2m", Data2Mem, 32'h55);
    tick();
    check_val("lat_idle_cen", {31'd0, CEN}, 32'd1);
    tick();
    check_val("lat2_c1_A", {25'd0, A}, 32'd9);
    check_val("lat2_c1_cen", {31'd0, CEN}, 32'd0);
    tick();
    check_val("lat2_c2_ready", {31'd0, d_ready}, 32'd1);
    check_val("lat2_c2_d2m", Data2Mem, 32'h99);
    d_req = 0;
    tick();

    // RD_LAT=3 debug read: OEN low cycles 1..3, ready and data in cycle 5.
    exp_oen3 = 5'b11000;
    e_d_req = 1; e_d_we = 0; e_d_addr = 7'd4; e_RDM = 32'hABC;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val("l3_oen", {31'd0, e_OEN}, {31'd0, exp_oen3[c]});
      check_val("l3_ready", {31'd0, e_d_ready}, {31'd0, (c == 4)});
    end
    check_val("l3_rdata", e_d_rdata, 32'hABC);
    e_d_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
